// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_MEM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Request-vector bit for a requester: bit 0 fetch, bit 1 data.
  function automatic logic [1:0] owner_onehot(input owner_e o);
    return (o == OWN_DM) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-requester picker; fixed data-over-fetch, or round-robin when ARB_RR_EN is defined.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_win,
  output logic [1:0] gnt_c,
  output owner_e     win_c
);

`ifdef ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  always_comb begin
    win_c = OWN_IF;
    if (req == 2'b11) begin
      win_c = (last_win == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (req[1]) begin
      win_c = OWN_DM;
    end
  end
`else
  logic unused_last_win;
  assign unused_last_win = last_win;

  always_comb begin
    win_c = req[1] ? OWN_DM : OWN_IF;
  end
`endif

  assign gnt_c = (req == 2'b00) ? 2'b00 : owner_onehot(win_c);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer sharing one synchronous memory between fetch and data ports.
// Build option: ARB_RR_EN selects round-robin arbitration instead of fixed data-over-fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  state_e             state, state_nxt;
  owner_e             owner, owner_nxt;
  owner_e             last_win, pick_win;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         req_m, pick_gnt;
  logic               arb_take;
  logic               if_gnt_nxt, dm_gnt_nxt, if_valid_nxt, dm_valid_nxt;
  logic               mem_en_nxt, mem_we_nxt, busy_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;

  // The owner keeps req high through its RESP cycle, so it is masked there.
  always_comb begin
    req_m = {dm_req, if_req};
    if (state == RESP) begin
      req_m = req_m & ~owner_onehot(owner);
    end
  end

  arb_pick u_pick (
    .req      (req_m),
    .last_win (last_win),
    .gnt_c    (pick_gnt),
    .win_c    (pick_win)
  );

  assign arb_take = ((state == IDLE) || (state == RESP)) && (pick_gnt != 2'b00);
  assign if_stall = if_req & ~if_valid;

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_win <= OWN_IF;
    end else if (arb_take) begin
      last_win <= pick_win;
    end
  end
`else
  assign last_win = OWN_IF;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    if_gnt_nxt    = 1'b0;
    dm_gnt_nxt    = 1'b0;
    if_valid_nxt  = 1'b0;
    dm_valid_nxt  = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;

    case (state)
      IDLE, RESP: begin
        if (arb_take) begin
          state_nxt  = ISSUE;
          owner_nxt  = pick_win;
          mem_en_nxt = 1'b1;
          if (pick_win == OWN_DM) begin
            dm_gnt_nxt    = 1'b1;
            mem_we_nxt    = dm_we;
            mem_addr_nxt  = dm_addr;
            mem_wdata_nxt = dm_wdata;
          end else begin
            if_gnt_nxt   = 1'b1;
            mem_addr_nxt = if_addr;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (mem_we) begin
          state_nxt    = RESP;
          dm_valid_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          if (owner == OWN_DM) begin
            dm_rdata_nxt = mem_rdata;
            dm_valid_nxt = 1'b1;
          end else begin
            if_rdata_nxt = mem_rdata;
            if_valid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
      if_gnt    <= if_gnt_nxt;
      dm_gnt    <= dm_gnt_nxt;
      if_valid  <= if_valid_nxt;
      dm_valid  <= dm_valid_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: two instances (MEM_LAT 1 and 3) checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int          N_CYC = 3000;

  logic clk;
  logic rst [2];
  logic if_req [2], if_gnt [2], if_valid [2], if_stall [2];
  logic dm_req [2], dm_we [2], dm_gnt [2], dm_valid [2];
  logic mem_en [2], mem_we [2], busy [2];
  logic [AW-1:0] if_addr [2], dm_addr [2], mem_addr [2];
  logic [DW-1:0] if_rdata [2], dm_rdata [2], dm_wdata [2], mem_wdata [2], mem_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_gnt    (if_gnt[g]),
      .if_rdata  (if_rdata[g]),
      .if_valid  (if_valid[g]),
      .if_stall  (if_stall[g]),
      .dm_req    (dm_req[g]),
      .dm_we     (dm_we[g]),
      .dm_addr   (dm_addr[g]),
      .dm_wdata  (dm_wdata[g]),
      .dm_gnt    (dm_gnt[g]),
      .dm_rdata  (dm_rdata[g]),
      .dm_valid  (dm_valid[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  // Reference model: one outstanding job with absolute issue/valid cycle numbers.
  bit          act [2], j_dm [2], j_st [2];
  int          j_iss [2], j_val [2];
  logic [31:0] j_addr [2], j_wd [2], j_data [2];
  logic [31:0] e_if_rd [2], e_dm_rd [2];
  bit          last_dm [2], zchk [2], if_seen [2], dm_seen [2], forced [2];
  bit          e_ifv [2], e_dmv [2];
  logic [31:0] mem [2][64];
  logic [31:0] shadow [2][64];
  logic [31:0] rd_v [2][8];
  bit          rd_ok [2][8];

  initial begin
    bit          iss, r_if, r_dm, pick_dm, tie_dm;
    int          slot;
    logic [31:0] v;
    string       p;

    n_chk = 0;
    n_err = 0;
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b0; if_req[l] = 1'b0; dm_req[l] = 1'b0; dm_we[l] = 1'b0;
      if_addr[l] = '0; dm_addr[l] = '0; dm_wdata[l] = '0; mem_rdata[l] = '0;
      act[l] = 1'b0; last_dm[l] = 1'b0; zchk[l] = 1'b1; forced[l] = 1'b0;
      if_seen[l] = 1'b0; dm_seen[l] = 1'b0;
      e_if_rd[l] = '0; e_dm_rd[l] = '0;
      for (int i = 0; i < 64; i++) begin
        v = $urandom;
        mem[l][i] = v;
        shadow[l][i] = v;
      end
      for (int i = 0; i < 8; i++) rd_ok[l][i] = 1'b0;
    end
    repeat (2) @(negedge clk);

    for (int n = 0; n < N_CYC; n++) begin
      for (int l = 0; l < 2; l++) begin
        p = $sformatf("L%0d c%0d", l, n);
        // Expected outputs for this cycle.
        iss      = act[l] && (n == j_iss[l]);
        e_ifv[l] = act[l] && !j_dm[l] && (n == j_val[l]);
        e_dmv[l] = act[l] && j_dm[l] && (n == j_val[l]);
        if (act[l] && (n == j_val[l]) && !j_st[l]) begin
          if (j_dm[l]) e_dm_rd[l] = j_data[l];
          else         e_if_rd[l] = j_data[l];
        end
        check_val({p, " if_gnt"},   32'(if_gnt[l]),   32'(iss && !j_dm[l]));
        check_val({p, " dm_gnt"},   32'(dm_gnt[l]),   32'(iss && j_dm[l]));
        check_val({p, " mem_en"},   32'(mem_en[l]),   32'(iss));
        check_val({p, " mem_we"},   32'(mem_we[l]),   32'(iss && j_st[l]));
        check_val({p, " if_valid"}, 32'(if_valid[l]), 32'(e_ifv[l]));
        check_val({p, " dm_valid"}, 32'(dm_valid[l]), 32'(e_dmv[l]));
        check_val({p, " busy"},     32'(busy[l]),     32'(act[l]));
        check_val({p, " if_rdata"}, if_rdata[l], e_if_rd[l]);
        check_val({p, " dm_rdata"}, dm_rdata[l], e_dm_rd[l]);
        if (iss) check_val({p, " mem_addr"}, mem_addr[l], j_addr[l]);
        if (iss && j_st[l]) check_val({p, " mem_wdata"}, mem_wdata[l], j_wd[l]);
        if (zchk[l]) begin
          check_val({p, " rst mem_addr"},  mem_addr[l],  32'h0);
          check_val({p, " rst mem_wdata"}, mem_wdata[l], 32'h0);
        end

        // Synchronous memory with MEM_LAT read latency, garbage outside the data window.
        if (mem_en[l] === 1'b1) begin
          if (mem_we[l] === 1'b1) begin
            mem[l][mem_addr[l][7:2]] = mem_wdata[l];
          end else begin
            slot = (n + lat_of(l)) % 8;
            rd_ok[l][slot] = 1'b1;
            rd_v[l][slot]  = mem[l][mem_addr[l][7:2]];
          end
        end
        slot = n % 8;
        mem_rdata[l] = rd_ok[l][slot] ? rd_v[l][slot] : $urandom;
        rd_ok[l][slot] = 1'b0;

        // Requesters and reset for this cycle; a held req drops the cycle after its valid.
        rst[l] = 1'b1;
        if (!forced[l] && act[l] && !j_st[l] && (n == j_iss[l] + 1)) begin
          rst[l] = 1'b0;
          forced[l] = 1'b1;
        end else if ($urandom_range(0, 199) == 0) begin
          rst[l] = 1'b0;
        end
        if (if_req[l] && if_seen[l]) begin
          if_req[l] = 1'b0;
        end else if (!if_req[l] && ($urandom_range(0, 2) != 0)) begin
          if_req[l]  = 1'b1;
          if_addr[l] = rand_addr();
        end
        if_seen[l] = e_ifv[l];
        if (dm_req[l] && dm_seen[l]) begin
          dm_req[l] = 1'b0;
        end else if (!dm_req[l] && ($urandom_range(0, 2) != 0)) begin
          dm_req[l]   = 1'b1;
          dm_we[l]    = 1'($urandom_range(0, 1));
          dm_addr[l]  = rand_addr();
          dm_wdata[l] = $urandom;
        end
        dm_seen[l] = e_dmv[l];

        // Model update at the edge closing this cycle.
        if (!rst[l]) begin
          act[l] = 1'b0; last_dm[l] = 1'b0; zchk[l] = 1'b1;
          e_if_rd[l] = '0; e_dm_rd[l] = '0;
        end else begin
          zchk[l] = 1'b0;
          if (!act[l] || (n == j_val[l])) begin
            r_if = if_req[l] && !(act[l] && !j_dm[l]);
            r_dm = dm_req[l] && !(act[l] && j_dm[l]);
            act[l] = 1'b0;
            if (r_if || r_dm) begin
`ifdef ARB_RR_EN
              tie_dm = !last_dm[l];
`else
              tie_dm = 1'b1;
`endif
              pick_dm = (r_if && r_dm) ? tie_dm : r_dm;
              last_dm[l] = pick_dm;
              act[l]   = 1'b1;
              j_dm[l]  = pick_dm;
              j_iss[l] = n + 1;
              if (pick_dm) begin
                j_st[l]   = dm_we[l];
                j_addr[l] = dm_addr[l];
                j_wd[l]   = dm_wdata[l];
              end else begin
                j_st[l]   = 1'b0;
                j_addr[l] = if_addr[l];
              end
              j_val[l] = j_st[l] ? n + 2 : n + 2 + lat_of(l);
              if (j_st[l]) shadow[l][j_addr[l][7:2]] = j_wd[l];
              else         j_data[l] = shadow[l][j_addr[l][7:2]];
            end
          end
        end
      end

      #1;
      for (int l = 0; l < 2; l++) begin
        check_val($sformatf("L%0d c%0d if_stall", l, n), 32'(if_stall[l]),
                  32'(if_req[l] && !e_ifv[l]));
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
